// File: rtl/warp_scheduler_if.sv
// Issue and writeback-update channels between the warp scheduler and the fetch/writeback stages.
// The master modport is the scheduler side; the slave modport is the fetch/writeback side.
interface warp_scheduler_if #(
    parameter int NUM_WARPS    = 8,
    parameter int WARP_WIDTH   = 32,
    parameter int R_ADDR_WIDTH = 10,
    parameter int PC_WIDTH     = 16,
    parameter int WID_DEPTH    = $clog2(NUM_WARPS)
) ();
    logic                    issue_valid;
    logic                    issue_ready;
    logic [WID_DEPTH-1:0]    issue_wid;
    logic [PC_WIDTH-1:0]     issue_pc;
    logic [WARP_WIDTH-1:0]   issue_mask;
    logic [R_ADDR_WIDTH-1:0] issue_base_reg;

    logic                    upd_valid;
    logic [WID_DEPTH-1:0]    upd_wid;
    logic [PC_WIDTH-1:0]     upd_pc;
    logic [WARP_WIDTH-1:0]   upd_mask;
    logic                    upd_done;

    modport master (
        output issue_valid, issue_wid, issue_pc, issue_mask, issue_base_reg,
        input  issue_ready,
        input  upd_valid, upd_wid, upd_pc, upd_mask, upd_done
    );

    modport slave (
        input  issue_valid, issue_wid, issue_pc, issue_mask, issue_base_reg,
        output issue_ready,
        output upd_valid, upd_wid, upd_pc, upd_mask, upd_done
    );
endinterface

// File: rtl/warp_scheduler.sv
// Warp slot table with lowest-free allocation, round-robin issue to fetch and writeback retire/update.
// Optional WARP_SCHED_STATS_EN adds issue_cnt / stall_cnt performance counters.
module warp_scheduler #(
    parameter int NUM_WARPS    = 8,
    parameter int WARP_WIDTH   = 32,
    parameter int R_ADDR_WIDTH = 10,
    parameter int PC_WIDTH     = 16,
    parameter int WID_DEPTH    = $clog2(NUM_WARPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wi,
    input  logic [WARP_WIDTH-1:0]   wmask_i,
    input  logic [R_ADDR_WIDTH-1:0] base_reg_i,
    output logic                    full,
    output logic                    idle,
    output logic                    alloc_err,
    warp_scheduler_if.master        bus
`ifdef WARP_SCHED_STATS_EN
    ,
    output logic [31:0]             issue_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    logic [NUM_WARPS-1:0]    valid_r;
    logic [NUM_WARPS-1:0]    inflight_r;
    logic [PC_WIDTH-1:0]     pc_r   [NUM_WARPS];
    logic [WARP_WIDTH-1:0]   mask_r [NUM_WARPS];
    logic [R_ADDR_WIDTH-1:0] base_r [NUM_WARPS];
    logic [WID_DEPTH-1:0]    rr_ptr_r;
    logic                    alloc_err_r;

    logic [NUM_WARPS-1:0]    eligible_s;
    logic [WID_DEPTH-1:0]    win_s;
    logic                    win_found_s;
    logic [WID_DEPTH-1:0]    free_s;
    logic                    alloc_s;
    logic                    hs_s;
    logic                    upd_ok_s;
    logic                    retire_s;

    assign eligible_s = valid_r & ~inflight_r;
    assign full       = &valid_r;
    assign idle       = ~|valid_r;
    assign alloc_err  = alloc_err_r;

    // Round-robin winner: first eligible slot after rr_ptr, wrapping naturally in WID_DEPTH bits.
    always_comb begin
        logic [WID_DEPTH-1:0] idx;
        logic                 hit;
        idx         = '0;
        hit         = 1'b0;
        win_s       = '0;
        win_found_s = 1'b0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            idx         = rr_ptr_r + WID_DEPTH'(k);
            hit         = eligible_s[idx] & ~win_found_s;
            win_s       = hit ? idx : win_s;
            win_found_s = win_found_s | hit;
        end
    end

    // Lowest-index free slot; scanning downward lets the lowest index overwrite last.
    always_comb begin
        free_s = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            free_s = valid_r[i] ? free_s : WID_DEPTH'(i);
        end
    end

    // Offer the winner to fetch; all fields forced to zero when nothing is eligible.
    always_comb begin
        bus.issue_valid    = win_found_s;
        bus.issue_wid      = win_found_s ? win_s : '0;
        bus.issue_pc       = win_found_s ? pc_r[win_s] : '0;
        bus.issue_mask     = win_found_s ? mask_r[win_s] : '0;
        bus.issue_base_reg = win_found_s ? base_r[win_s] : '0;
    end

    // Event decode; allocation, issue and update always target distinct slots.
    always_comb begin
        alloc_s  = wi & ~full;
        hs_s     = win_found_s & bus.issue_ready;
        upd_ok_s = bus.upd_valid & valid_r[bus.upd_wid] & inflight_r[bus.upd_wid];
        retire_s = upd_ok_s & (bus.upd_done | (bus.upd_mask == '0));
    end

    // Slot table, round-robin pointer and sticky allocation error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_r     <= '0;
            inflight_r  <= '0;
            rr_ptr_r    <= WID_DEPTH'(NUM_WARPS - 1);
            alloc_err_r <= 1'b0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                pc_r[i]   <= '0;
                mask_r[i] <= '0;
                base_r[i] <= '0;
            end
        end else begin
            if (alloc_s) begin
                valid_r[free_s]    <= 1'b1;
                inflight_r[free_s] <= 1'b0;
                pc_r[free_s]       <= '0;
                mask_r[free_s]     <= wmask_i;
                base_r[free_s]     <= base_reg_i;
            end
            if (wi && full) begin
                alloc_err_r <= 1'b1;
            end
            if (hs_s) begin
                inflight_r[win_s] <= 1'b1;
                rr_ptr_r          <= win_s;
            end
            if (upd_ok_s) begin
                inflight_r[bus.upd_wid] <= 1'b0;
                if (retire_s) begin
                    valid_r[bus.upd_wid] <= 1'b0;
                end else begin
                    pc_r[bus.upd_wid]   <= bus.upd_pc;
                    mask_r[bus.upd_wid] <= bus.upd_mask;
                end
            end
        end
    end

`ifdef WARP_SCHED_STATS_EN
    logic [31:0] issue_cnt_r;
    logic [31:0] stall_cnt_r;

    // Free-running wrap-around counters of accepted issues and back-pressured offers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (hs_s) begin
                issue_cnt_r <= issue_cnt_r + 32'd1;
            end
            if (win_found_s && !bus.issue_ready) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign issue_cnt = issue_cnt_r;
    assign stall_cnt = stall_cnt_r;
`endif

endmodule
